vaccine_slot_scheduler: RTL and testbench

VACCINE_SLOT_SCHEDULER -- requirements
Module: vaccine_slot_scheduler

---
 rtl/vaccine_pkg.sv | 25 ++
 rtl/vaccine_slot_scheduler_if.sv | 28 ++
 rtl/rr_free_finder.sv | 33 +++
 rtl/vaccine_slot_scheduler.sv | 127 ++++++++++++
 tb/tb_vaccine_slot_scheduler.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/vaccine_pkg.sv
// Shared types and constants for the vaccine slot scheduler.
//   NUM_SLOTS      default number of vaccine object slots
//   SPAWN_X_OFFSET left margin added to the random spawn X
//   LFSR_SEED      reset value of the spawn-position LFSR
package vaccine_pkg;

  localparam int unsigned NUM_SLOTS      = 10;
  localparam int unsigned SPAWN_X_OFFSET = 32;
  localparam int unsigned LFSR_W         = 10;
  localparam int unsigned X_W            = 10;
  localparam int unsigned CNT_W          = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SPAWN = 2'd2
  } sched_state_t;

  // One step of the x^10 + x^7 + 1 Fibonacci LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[9] ^ v[6]};
  endfunction

endpackage

// File: rtl/vaccine_slot_scheduler_if.sv
// Game-side bundle of the vaccine slot scheduler.
//   master: game logic / bench, drives frame, enable, collision and off-screen
//   slave : scheduler, drives slot enables, spawn strobes/position, score strobes
interface vaccine_slot_scheduler_if import vaccine_pkg::*; #(
  parameter int unsigned N = NUM_SLOTS
) ();

  logic           startOfFrame;
  logic           gameEnable;
  logic [N-1:0]   collision;
  logic [N-1:0]   offScreen;
  logic [N-1:0]   vaccineActive;
  logic [N-1:0]   spawnPulse;
  logic [X_W-1:0] spawnX;
  logic           hitPulse;
  logic           dropPulse;

  modport master (
    output startOfFrame, gameEnable, collision, offScreen,
    input  vaccineActive, spawnPulse, spawnX, hitPulse, dropPulse
  );

  modport slave (
    input  startOfFrame, gameEnable, collision, offScreen,
    output vaccineActive, spawnPulse, spawnX, hitPulse, dropPulse
  );

endinterface

// File: rtl/rr_free_finder.sv
// Combinational round-robin search for the first free slot.
//   free  : 1 = slot available
//   start : first slot index examined; search wraps from N-1 to 0
//   found : at least one slot is free
//   grant : one-hot of the chosen slot, zero when nothing is free
module rr_free_finder import vaccine_pkg::*; #(
  parameter int unsigned N  = NUM_SLOTS,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  free,
  input  logic [PW-1:0] start,
  output logic          found,
  output logic [N-1:0]  grant
);

  int unsigned idx;

  // Walk N positions from start, modulo N; the first free one wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(start) + i;
      if (idx >= N) idx = idx - N;
      if (!found && free[PW'(idx)]) begin
        found             = 1'b1;
        grant[PW'(idx)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vaccine_slot_scheduler.sv
// Vaccine slot scheduler: every SPAWN_FRAMES frames it spawns a vaccine into
// the next free slot (round-robin), and retires slots on hit or off-screen.
//   clk, resetN : pixel clock, asynchronous active-low reset
//   bus (slave) : startOfFrame, gameEnable, collision, offScreen in;
//                 vaccineActive, spawnPulse, spawnX, hitPulse, dropPulse out
module vaccine_slot_scheduler import vaccine_pkg::*; #(
  parameter int unsigned SPAWN_FRAMES = 60,
  parameter int unsigned NUM_SLOTS    = vaccine_pkg::NUM_SLOTS
) (
  input  logic                    clk,
  input  logic                    resetN,
  vaccine_slot_scheduler_if.slave bus
);

  localparam int unsigned PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  sched_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d, ptr_after;
  logic [LFSR_W-1:0]    lfsr_q;
  logic [NUM_SLOTS-1:0] coll_q;
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [NUM_SLOTS-1:0] spawn_q, spawn_d;
  logic [NUM_SLOTS-1:0] hit_mask, off_mask, grant;
  logic                 hit_q, hit_d, drop_q, drop_d, found;

  // Rising collision edges and off-screen events only count on live slots.
  assign hit_mask = bus.collision & ~coll_q & active_q;
  assign off_mask = bus.offScreen & active_q;

  rr_free_finder #(.N(NUM_SLOTS)) u_finder (
    .free  (~active_q),
    .start (ptr_q),
    .found (found),
    .grant (grant)
  );

  // Pointer value after granting: one past the chosen slot, wrapping.
  always_comb begin
    ptr_after = ptr_q;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (grant[i]) ptr_after = (i == NUM_SLOTS - 1) ? '0 : PW'(i + 1);
    end
  end

  // Next state and next registered outputs. The slot choice is made on the
  // edge entering SPAWN from the pre-clear mask, so a slot freed in the same
  // clock waits for the following spawn; the grant is committed on the edge
  // leaving SPAWN, after clears, so the spawn wins over a stale hit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    spawn_d  = '0;
    drop_d   = 1'b0;
    hit_d    = |hit_mask;
    active_d = (active_q & ~(hit_mask | off_mask)) | spawn_q;

    case (state_q)
      IDLE: begin
        if (bus.gameEnable) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(SPAWN_FRAMES)) begin
          state_d = SPAWN;
          cnt_d   = '0;
          spawn_d = grant;
          drop_d  = ~found;
          if (found) ptr_d = ptr_after;
        end else if (bus.startOfFrame) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SPAWN: begin
        state_d = WAIT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!bus.gameEnable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      ptr_d    = '0;
      active_d = '0;
      spawn_d  = '0;
      hit_d    = 1'b0;
      drop_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      coll_q   <= '0;
      active_q <= '0;
      spawn_q  <= '0;
      hit_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      lfsr_q   <= lfsr_next(lfsr_q);
      coll_q   <= bus.collision;
      active_q <= active_d;
      spawn_q  <= spawn_d;
      hit_q    <= hit_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.vaccineActive = active_q;
  assign bus.spawnPulse    = spawn_q;
  assign bus.hitPulse      = hit_q;
  assign bus.dropPulse     = drop_q;
  assign bus.spawnX        = {1'b0, lfsr_q[8:0]} + X_W'(SPAWN_X_OFFSET);

endmodule

// File: tb/tb_vaccine_slot_scheduler.sv
// Self-checking bench for vaccine_slot_scheduler (SPAWN_FRAMES=3, 10 slots).
module tb_vaccine_slot_scheduler;

  localparam int NS = 10;
  localparam int SF = 3;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  vaccine_slot_scheduler_if #(.N(NS)) bus ();

  vaccine_slot_scheduler #(.SPAWN_FRAMES(SF), .NUM_SLOTS(NS)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NS-1:0] exp_spawn;
    logic          exp_drop;
    logic [NS-1:0] exp_active;
  } period_vec_t;

  period_vec_t vec [11];

  // Reference model: slot set as a bit mask, frame count, spawn pending.
  logic [NS-1:0] m_act, m_colq;
  int            m_ptr, m_frames, m_spawn_slot, m_lfsr;
  bit            m_running, m_in_spawn, m_hit, m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_act = '0; m_colq = '0; m_ptr = 0; m_frames = 0; m_spawn_slot = -1;
    m_lfsr = 1; m_running = 0; m_in_spawn = 0; m_hit = 0; m_drop = 0;
  endfunction

  task automatic model_step();
    logic [NS-1:0] old, rise, tmp;
    int pick, s;
    old  = m_act;
    rise = bus.collision & ~m_colq;
    m_lfsr = ((m_lfsr * 2) % 1024) + (((m_lfsr / 512) + (m_lfsr / 64)) % 2);
    pick = -1; m_hit = 0; m_drop = 0;
    if (!bus.gameEnable) begin
      m_act = '0; m_running = 0; m_in_spawn = 0; m_frames = 0; m_ptr = 0;
    end else begin
      m_hit = ((rise & old) != '0);
      m_act = old & ~(rise | bus.offScreen);
      if (m_spawn_slot >= 0) m_act = m_act | (NS'(1) << m_spawn_slot);
      if (!m_running) begin
        m_running = 1; m_frames = 0;
      end else if (m_in_spawn) begin
        m_in_spawn = 0;
      end else if (m_frames == SF) begin
        m_frames = 0; m_in_spawn = 1;
        for (int k = 0; k < NS; k++) begin
          s = (m_ptr + k) % NS;
          tmp = old >> s;
          if (pick < 0 && !tmp[0]) pick = s;
        end
        if (pick >= 0) m_ptr = (pick + 1) % NS;
        else m_drop = 1;
      end else if (bus.startOfFrame) begin
        m_frames++;
      end
    end
    m_spawn_slot = pick;
    m_colq = bus.collision;
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetN) model_step(); else model_reset();
    #1;
  endtask

  task automatic compare_model();
    logic [NS-1:0] es;
    es = (m_spawn_slot >= 0) ? (NS'(1) << m_spawn_slot) : '0;
    chk("m_active", 32'(bus.vaccineActive), 32'(m_act));
    chk("m_spawn", 32'(bus.spawnPulse), 32'(es));
    chk("m_hit", 32'(bus.hitPulse), 32'(m_hit));
    chk("m_drop", 32'(bus.dropPulse), 32'(m_drop));
    chk("m_spawnx", 32'(bus.spawnX), 32'((m_lfsr % 512) + 32));
  endtask

  // SF frame pulses; returns in the SPAWN clock.
  task automatic period_to_spawn();
    repeat (SF) begin
      bus.startOfFrame = 1'b1; tick();
      bus.startOfFrame = 1'b0; tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int hits;
    bit inrange;
    for (int i = 0; i < 10; i++) begin
      vec[i].exp_spawn  = NS'(1) << i;
      vec[i].exp_drop   = 1'b0;
      vec[i].exp_active = NS'((1 << (i + 1)) - 1);
    end
    vec[10].exp_spawn  = '0;
    vec[10].exp_drop   = 1'b1;
    vec[10].exp_active = '1;

    resetN = 1'b0;
    bus.gameEnable = 1'b0; bus.startOfFrame = 1'b0;
    bus.collision = '0; bus.offScreen = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_active", 32'(bus.vaccineActive), 0);
    chk("rst_spawn", 32'(bus.spawnPulse), 0);
    chk("rst_hit", 32'(bus.hitPulse), 0);
    chk("rst_drop", 32'(bus.dropPulse), 0);
    chk("rst_spawnx", 32'(bus.spawnX), 33);

    resetN = 1'b1; bus.gameEnable = 1'b1; tick();

    // Fill all slots in order, then one dropped attempt.
    for (int p = 0; p < 11; p++) begin
      period_to_spawn();
      chk($sformatf("fill%0d_spawn", p), 32'(bus.spawnPulse), 32'(vec[p].exp_spawn));
      chk($sformatf("fill%0d_drop", p), 32'(bus.dropPulse), 32'(vec[p].exp_drop));
      tick();
      chk($sformatf("fill%0d_active", p), 32'(bus.vaccineActive), 32'(vec[p].exp_active));
    end

    // Held collision gives one hit; freed slot is the next spawn target.
    hits = 0;
    bus.collision = NS'(10'h010);
    repeat (5) begin tick(); hits += int'(bus.hitPulse); end
    bus.collision = '0; tick(); hits += int'(bus.hitPulse);
    chk("hold_hits", 32'(hits), 1);
    chk("hold_active", 32'(bus.vaccineActive), 32'h3EF);
    period_to_spawn();
    chk("respawn4", 32'(bus.spawnPulse), 32'h010);
    tick();
    chk("respawn4_active", 32'(bus.vaccineActive), 32'h3FF);

    // Off-screen retires without scoring; inactive slots ignore events.
    bus.offScreen = ~NS'(10'h084); tick(); bus.offScreen = '0;
    chk("off_hit", 32'(bus.hitPulse), 0);
    chk("off_active", 32'(bus.vaccineActive), 32'h084);
    bus.offScreen = NS'(10'h008); tick(); bus.offScreen = '0;
    chk("off3_active", 32'(bus.vaccineActive), 32'h084);
    bus.collision = NS'(10'h020); tick(); bus.collision = '0;
    chk("inactive_hit", 32'(bus.hitPulse), 0);
    chk("inactive_active", 32'(bus.vaccineActive), 32'h084);
    tick();
    bus.collision = NS'(10'h084); tick();
    chk("dual_hit", 32'(bus.hitPulse), 1);
    chk("dual_active", 32'(bus.vaccineActive), 0);
    bus.collision = '0; tick();
    chk("dual_single", 32'(bus.hitPulse), 0);

    // Six spawns from pointer 5, then disable and restart.
    repeat (6) begin period_to_spawn(); tick(); end
    chk("six_active", 32'(bus.vaccineActive), 32'h3E1);
    bus.gameEnable = 1'b0; tick();
    chk("dis_active", 32'(bus.vaccineActive), 0);
    chk("dis_spawn", 32'(bus.spawnPulse), 0);
    tick();
    bus.gameEnable = 1'b1; tick();
    period_to_spawn();
    chk("restart_slot0", 32'(bus.spawnPulse), 32'h001);
    tick();

    // Reset asserted during the SPAWN clock.
    period_to_spawn();
    chk("pre_rst_spawn", 32'(bus.spawnPulse), 32'h002);
    resetN = 1'b0; model_reset(); #1;
    chk("mid_rst_spawn", 32'(bus.spawnPulse), 0);
    chk("mid_rst_active", 32'(bus.vaccineActive), 0);
    chk("mid_rst_hit", 32'(bus.hitPulse), 0);
    chk("mid_rst_drop", 32'(bus.dropPulse), 0);
    tick(); tick();
    resetN = 1'b1; tick();
    chk("post_rst_active", 32'(bus.vaccineActive), 0);

    // Random traffic against the model; spawnX range over >1023 clocks.
    for (int c = 0; c < 1500; c++) begin
      bus.gameEnable   = ($urandom_range(0, 199) != 0);
      bus.startOfFrame = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b < NS; b++)
          bus.collision = (bus.collision << 1) | NS'($urandom_range(0, 7) == 0);
      end
      bus.offScreen = '0;
      for (int b = 0; b < NS; b++)
        bus.offScreen = (bus.offScreen << 1) | NS'($urandom_range(0, 31) == 0);
      tick();
      compare_model();
      inrange = (bus.spawnX >= 10'd32) && (bus.spawnX <= 10'd543);
      chk("spawnx_range", 32'(inrange), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
